// File: rtl/nav_ram_sched.sv
// ============================================================================
// nav_ram_sched : single-port nav-record RAM scheduler (skid write, RR arb)
// Optional: NAV_SCHED_WRAP_EN selects ring-buffer mode.   Revision: 1.0
// ============================================================================
`default_nettype none

module nav_ram_sched #(
  parameter int DW     = 93,
  parameter int AW     = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_err_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_wdata_o,
  input  logic [DW-1:0] ram_rdata_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW:0]   rec_cnt_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD   = 3'd2,
    S_RW   = 3'd3,
    S_RSP  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic            buf_full_q, buf_full_d;
  logic [DW-1:0]   buf_q, buf_d;
  logic            last_wr_q, last_wr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rec_cnt_q, rec_cnt_d;
  logic            ovf_q, ovf_d;
  logic [1:0]      lat_q, lat_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            ram_en_q, ram_we_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   ram_wdata_q;

  logic            full;
  logic            wr_grant;
  logic            rd_oob;
  logic            wr_accept;
  logic [AW-1:0]   wr_ptr_inc;

`ifdef NAV_SCHED_WRAP_EN
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  assign full       = 1'b0;
  assign wr_ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
`else
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
  // A record waiting in the skid buffer already owns a slot.
  assign full       = ({1'b0, rec_cnt_q} + {{(AW+1){1'b0}}, buf_full_q}) >= DEPTH_W;
  assign wr_ptr_inc = wr_ptr_q + AW'(1);
`endif

  assign wr_grant  = buf_full_q && (!rd_req_i || !last_wr_q);
  assign rd_oob    = {1'b0, rd_addr_i} >= rec_cnt_q;
  assign wr_accept = !full && (!buf_full_q || (state_q == S_WR));

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    last_wr_d  = last_wr_q;
    wr_ptr_d   = wr_ptr_q;
    rec_cnt_d  = rec_cnt_q;
    ovf_d      = ovf_q;
    lat_d      = lat_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (wr_grant) begin
          state_d   = S_WR;
          last_wr_d = 1'b1;
        end else if (rd_req_i) begin
          state_d   = rd_oob ? S_ERR : S_RD;
          last_wr_d = 1'b0;
        end
      end
      S_WR: begin
        buf_full_d = 1'b0;
        wr_ptr_d   = wr_ptr_inc;
        if (rec_cnt_q != DEPTH_C) rec_cnt_d = rec_cnt_q + (AW+1)'(1);
        state_d    = S_IDLE;
      end
      S_RD: begin
        lat_d   = '0;
        state_d = S_RW;
      end
      S_RW: begin
        if (lat_q == LAT_LAST) begin
          rd_data_d = ram_rdata_i;
          state_d   = S_RSP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RSP, S_ERR: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase

    // Capture after the drain so a same-edge refill in S_WR keeps the buffer full.
    if (wr_req_i && wr_accept) begin
      buf_full_d = 1'b1;
      buf_d      = wr_data_i;
    end

    if (wr_req_i && !wr_accept) ovf_d = 1'b1;
    else if (ovf_clr_i)         ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      last_wr_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rec_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      lat_q       <= '0;
      rd_data_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      last_wr_q  <= last_wr_d;
      wr_ptr_q   <= wr_ptr_d;
      rec_cnt_q  <= rec_cnt_d;
      ovf_q      <= ovf_d;
      lat_q      <= lat_d;
      rd_data_q  <= rd_data_d;
      ram_en_q   <= (state_d == S_WR) || (state_d == S_RD);
      ram_we_q   <= (state_d == S_WR);
      if (state_d == S_WR) begin
        ram_addr_q  <= wr_ptr_q;
        ram_wdata_q <= buf_q;
      end else if (state_d == S_RD) begin
        ram_addr_q  <= rd_addr_i;
      end
    end
  end

  assign rd_valid_o  = (state_q == S_RSP) || (state_q == S_ERR);
  assign rd_err_o    = (state_q == S_ERR);
  assign rd_data_o   = (state_q == S_RSP) ? rd_data_q : '0;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign rec_cnt_o   = rec_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nav_ram_sched.sv
// ============================================================================
// tb_nav_ram_sched : directed self-checking bench for nav_ram_sched (DEPTH=4)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nav_ram_sched;
  localparam int DW     = 93;
  localparam int AW     = 8;
  localparam int DEPTH  = 4;
  localparam int RD_LAT = 1;
`ifdef NAV_SCHED_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_req, rd_req, ovf_clr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic          rd_valid, rd_err, ram_en, ram_we, ovf;
  logic [DW-1:0] rd_data, ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr, wr_ptr;
  logic [AW:0]   rec_cnt;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nav_ram_sched #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req_i(wr_req), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .wr_ptr_o(wr_ptr), .rec_cnt_o(rec_cnt), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
  );

  // Single-port RAM model with one cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
    wr_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; ovf_clr = 1'b0;
    wr_data = '0; rd_addr = '0;
    #2;
    checks++;
    if ({ram_en, ram_we, rd_valid, rd_err, ovf} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got en=%b we=%b rv=%b err=%b ovf=%b required all 0",
               ram_en, ram_we, rd_valid, rd_err, ovf);
    end
    checks++;
    if ({ram_addr, wr_ptr, rec_cnt, rd_data, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_values: got addr=%0d ptr=%0d cnt=%0d rdata=%0h wdata=%0h required 0",
               ram_addr, wr_ptr, rec_cnt, rd_data, ram_wdata);
    end
    do_reset();
  endtask

  task automatic test_write();
    wr_req = 1'b1; wr_data = 93'h1;
    tick(); wr_req = 1'b0;
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'd0, 93'h1}) begin
      failures++;
      $display("FAIL write1: got en=%b we=%b addr=%0d wdata=%0h required 1 1 0 1",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick(); tick();
    wr_req = 1'b1; wr_data = 93'h2;
    tick(); wr_req = 1'b0;
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'd1, 93'h2}) begin
      failures++;
      $display("FAIL write2: got en=%b we=%b addr=%0d wdata=%0h required 1 1 1 2",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick();
    checks++;
    if (wr_ptr !== 8'd2 || rec_cnt !== 9'd2) begin
      failures++;
      $display("FAIL write_counts: got ptr=%0d cnt=%0d required 2 2", wr_ptr, rec_cnt);
    end
  endtask

  task automatic test_read();
    rd_req = 1'b1; rd_addr = 8'd1;
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'd1}) begin
      failures++;
      $display("FAIL read_strobe: got en=%b we=%b addr=%0d required 1 0 1", ram_en, ram_we, ram_addr);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL read_early: got rd_valid=%b required 0", rd_valid);
    end
    tick();
    checks++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 93'h2}) begin
      failures++;
      $display("FAIL read_resp: got rv=%b err=%b data=%0h required 1 0 2", rd_valid, rd_err, rd_data);
    end
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_error();
    rd_req = 1'b1; rd_addr = 8'd5;
    tick();
    checks++;
    if ({rd_valid, rd_err, ram_en, rd_data} !== {1'b1, 1'b1, 1'b0, 93'h0}) begin
      failures++;
      $display("FAIL rd_err_resp: got rv=%b err=%b en=%b data=%0h required 1 1 0 0",
               rd_valid, rd_err, ram_en, rd_data);
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if ({rd_valid, ram_en} !== 2'b00) begin
      failures++;
      $display("FAIL rd_err_after: got rv=%b en=%b required 0 0", rd_valid, ram_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_ptr;
    exp_ptr = WRAP ? 8'd0 : 8'd4;
    wr_req = 1'b1; wr_data = 93'hA;
    tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 8'd0;
    tick();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'd2, 93'hA}) begin
      failures++;
      $display("FAIL b2b_w1: got en=%b we=%b addr=%0d wdata=%0h required 1 1 2 a",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    wr_req = 1'b1; wr_data = 93'hB;
    tick(); wr_data = 93'hC;
    checks++;
    if ({ram_en, ovf} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_gap: got en=%b ovf=%b required 0 0", ram_en, ovf);
    end
    tick(); wr_req = 1'b0;
    checks++;
    if ({ram_en, ram_we, ram_addr, ovf} !== {1'b1, 1'b0, 8'd0, 1'b1}) begin
      failures++;
      $display("FAIL b2b_rd: got en=%b we=%b addr=%0d ovf=%b required 1 0 0 1",
               ram_en, ram_we, ram_addr, ovf);
    end
    tick(); tick();
    checks++;
    if ({rd_valid, rd_err, rd_data} !== {1'b1, 1'b0, 93'h1}) begin
      failures++;
      $display("FAIL b2b_resp: got rv=%b err=%b data=%0h required 1 0 1", rd_valid, rd_err, rd_data);
    end
    rd_req = 1'b0;
    tick(); tick();
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'd3, 93'hB}) begin
      failures++;
      $display("FAIL b2b_w2: got en=%b we=%b addr=%0d wdata=%0h required 1 1 3 b",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    tick();
    checks++;
    if (rec_cnt !== 9'd4 || wr_ptr !== exp_ptr) begin
      failures++;
      $display("FAIL b2b_counts: got cnt=%0d ptr=%0d required 4 %0d", rec_cnt, wr_ptr, exp_ptr);
    end
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: got ovf=%b required 0", ovf);
    end
  endtask

  task automatic test_full();
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_req = 1'b1; wr_data = 93'h10 + DW'(i);
      tick(); wr_req = 1'b0;
      tick();
      exp_we   = (i < 4) || WRAP;
      exp_addr = exp_we ? AW'(i % 4) : ram_addr;
      checks++;
      if ({ram_en, ram_we} !== {exp_we, exp_we} || (exp_we && ram_addr !== exp_addr)) begin
        failures++;
        $display("FAIL full_write%0d: got en=%b we=%b addr=%0d required %b %b %0d",
                 i, ram_en, ram_we, ram_addr, exp_we, exp_we, exp_addr);
      end
      tick(); tick();
    end
    checks++;
    if (rec_cnt !== 9'd4 || ovf !== !WRAP || wr_ptr !== (WRAP ? 8'd1 : 8'd4)) begin
      failures++;
      $display("FAIL full_state: got cnt=%0d ovf=%b ptr=%0d required 4 %b %0d",
               rec_cnt, ovf, wr_ptr, !WRAP, WRAP ? 1 : 4);
    end
  endtask

  task automatic test_reset_midop();
    bit seen_valid;
    do_reset();
    wr_req = 1'b1; wr_data = 93'h5;
    tick(); wr_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_en, ram_we, wr_ptr} !== {1'b0, 1'b0, 8'd0}) begin
      failures++;
      $display("FAIL rst_in_wr: got en=%b we=%b ptr=%0d required 0 0 0", ram_en, ram_we, wr_ptr);
    end
    tick(); tick(); rst_n = 1'b1;
    tick();
    wr_req = 1'b1; wr_data = 93'h5;
    tick(); wr_req = 1'b0;
    tick(); tick(); tick();
    rd_req = 1'b1; rd_addr = 8'd0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_en, rd_valid} !== 2'b00) begin
      failures++;
      $display("FAIL rst_in_rw: got en=%b rv=%b required 0 0", ram_en, rd_valid);
    end
    rd_req = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rd_valid === 1'b1 || ram_en === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || wr_ptr !== 8'd0 || rec_cnt !== 9'd0) begin
      failures++;
      $display("FAIL rst_release: got activity=%b ptr=%0d cnt=%0d required 0 0 0",
               seen_valid, wr_ptr, rec_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_full();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
